mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative RV32M multiply/divide unit. It sits between the register file read ports and the writeback path of the processor. It takes operands READ_DATA_A/B, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles, and presents RESULT plus the destination register tag with a one-cycle DONE strobe. That strobe drives the register file write enable, data and write-address inputs.

Parameters:
XLEN, 32, operand/result width; only 32 supported.
CNT_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-high reset.
START  in  1  request strobe; sampled only in IDLE.
KILL  in  1  synchronous abort of the in-flight operation.
FUNCT3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
OPERAND_A  in  XLEN  rs1 value (dividend / multiplicand).
OPERAND_B  in  XLEN  rs2 value (divisor / multiplier).
RD_IN  in  5  destination register tag.
BUSY  out  1  high while not IDLE.
DONE  out  1  one-cycle completion strobe; maps to the register file write enable.
RESULT  out  XLEN  result; maps to the register file write data.
RD_OUT  out  5  latched tag; maps to the register file write address.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; BUSY, DONE, RESULT and RD_OUT all 0; internal accumulators and counter cleared.
- States:
  - IDLE: START=1 latches FUNCT3, RD_IN and operand magnitudes and signs.
    - Special divide case -> FINISH.
    - Otherwise counter=31 -> CALC.
  - CALC: one radix-2 step per cycle.
    - Multiply: shift-add into a 64-bit product.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - Counter decrements; at counter==0 -> FINISH.
  - FINISH: applies sign correction, selects the 32-bit result, registers RESULT and RD_OUT, sets DONE -> IDLE.
- Latency, with START high in cycle N:
  - Normal op: CALC occupies N+1..N+32, FINISH is N+33, DONE=1 in cycle N+34 only.
  - Special case: FINISH is N+1, DONE=1 in N+2.
  - BUSY=1 in every non-IDLE cycle; BUSY=0 in the DONE cycle.
- Operand signedness:
  - Signed A: MULH, MULHSU, DIV, REM. Signed B: MULH, DIV, REM. All others unsigned.
  - Signed operands are converted to magnitude on entry.
  - Result sign: product = signA^signB; quotient = signA^signB; remainder = signA.
- Result select: MUL = product[31:0]; MULH* = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
- Division by zero: quotient 0xFFFFFFFF, remainder = OPERAND_A, for both signed and unsigned ops.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- START while BUSY: ignored, no queueing.
- START in the DONE cycle: accepted, since state is IDLE.
- RESULT and RD_OUT hold their value until the next FINISH.
- KILL in CALC or FINISH: return to IDLE next cycle, no DONE, RESULT unchanged. KILL in IDLE has priority over START (request dropped).
- Reset mid-operation: immediate return to reset values, no DONE.
- RD_IN=0 still completes with DONE; suppressing writes to x0 is not this block's job.

Decomposition:
- Package mdu_pkg:
  - XLEN constant.
  - FUNCT3 op enum mdu_op_e.
  - FSM enum mdu_state_e {IDLE, CALC, FINISH}.
  - Special-case result constants DIV0_Q=0xFFFFFFFF, OVF_Q=0x80000000.
- One sub-module, mdu_iter_core: the shared shift/add/subtract datapath step.
  - Inputs: mode (mul/div), accumulator, operand.
  - Outputs: next accumulator.
  - Purely combinational.
- The parent module owns the FSM, counter, sign handling and output registers.

Test Plan:
1. MUL 7 x 0xFFFFFFFD (-3), RD_IN=5, START in cycle N -> RESULT 0xFFFFFFEB, RD_OUT 5, DONE only in cycle N+34, BUSY high N+1..N+33.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIV 5/0 -> 0xFFFFFFFF with DONE at N+2; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
5. START pulsed at N+10 during a DIV -> ignored, single DONE at N+34. KILL at N+15 -> BUSY low at N+16, no DONE, RESULT unchanged. RST asserted mid-CALC -> BUSY, DONE, RESULT, RD_OUT read 0 before the next edge.
6. Back-to-back: new START (MUL 3x4, RD_IN=9) in the DONE cycle of a previous op -> first RESULT/RD_OUT correct, second DONE 34 cycles later with RESULT 12, RD_OUT 9.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants and types for the RV32M multiply/divide unit
// Contents: XLEN/CNT_W widths, funct3 op enum, FSM state enum,
//           special-case divide results, magnitude helper.
package mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } mdu_state_e;

  localparam logic [XLEN-1:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_Q  = 32'h8000_0000;

  function automatic logic [XLEN-1:0] to_mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - one radix-2 shift/add (multiply) or shift/subtract (divide) step
// Ports:
//   mode_div  in   0 = multiply step, 1 = divide step
//   acc       in   2*XLEN accumulator; mul {product_hi, multiplier/product_lo}, div {remainder, quotient/dividend}
//   operand   in   XLEN multiplicand (mul) or divisor (div) magnitude
//   acc_next  out  accumulator after one step
module mdu_iter_core
  import mdu_pkg::*;
(
  input  logic              mode_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] top;
  logic [XLEN:0] diff;

  always_comb begin
    // Multiply: conditionally add into the high half, then shift the whole
    // accumulator right; the carry becomes the new top bit.
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: partial remainder after shifting in the next dividend bit.
    top  = acc[2*XLEN-1:XLEN-1];
    diff = top - {1'b0, operand};
    if (!mode_div) begin
      acc_next = {sum, acc[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {top[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit feeding the register file write port
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, kill         request strobe (sampled in IDLE), abort of in-flight op
//   funct3              op select (MUL..REMU)
//   operand_a/b         rs1 / rs2 values
//   rd_in               destination register tag
//   busy                high while not IDLE
//   done                one-cycle completion strobe (register file write enable)
//   result, rd_out      registered result and tag (write data / write address)
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  mdu_state_e        state, state_d;
  mdu_op_e           op_in, op_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_next, acc_in, prod;
  logic [XLEN-1:0]   opnd, opnd_in, mag_a, mag_b, quo, rem_c, fin;
  logic [4:0]        rd_q;
  logic              neg_q, neg_in;
  logic              a_signed, b_signed, sign_a, sign_b, div0, ovf, special;

  assign op_in = mdu_op_e'(funct3);
  assign busy  = (state != IDLE);

  // Operand preparation for a new request.
  always_comb begin
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    sign_a   = a_signed & operand_a[XLEN-1];
    sign_b   = b_signed & operand_b[XLEN-1];
    mag_a    = to_mag(operand_a, sign_a);
    mag_b    = to_mag(operand_b, sign_b);
    div0     = funct3[2] && (operand_b == '0);
    ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (operand_a == OVF_Q) && (operand_b == '1);
    special  = div0 | ovf;
    neg_in   = 1'b0;
    acc_in   = '0;
    opnd_in  = '0;
    if (!funct3[2]) begin
      neg_in  = sign_a ^ sign_b;
      acc_in  = {{XLEN{1'b0}}, mag_b};
      opnd_in = mag_a;
    end else begin
      // A divide-by-zero quotient stays all-ones; its remainder gets sign_a
      // back, which reproduces operand_a exactly.
      neg_in  = funct3[1] ? sign_a : ((sign_a ^ sign_b) & ~div0);
      opnd_in = mag_b;
      if (div0) begin
        acc_in = {mag_a, DIV0_Q};
      end else if (ovf) begin
        acc_in = {{XLEN{1'b0}}, OVF_Q};
      end else begin
        acc_in = {{XLEN{1'b0}}, mag_a};
      end
    end
  end

  mdu_iter_core u_core (
    .mode_div (op_q[2]),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (acc_next)
  );

  // Sign correction and result select.
  always_comb begin
    prod  = neg_q ? -acc : acc;
    quo   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_c = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       fin = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin = quo;
      default:                      fin = rem_c;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start && !kill) state_d = special ? FINISH : CALC;
      CALC:    if (kill) state_d = IDLE;
               else if (cnt == '0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_MUL;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      rd_q   <= '0;
      result <= '0;
      rd_out <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !kill) begin
          op_q  <= op_in;
          rd_q  <= rd_in;
          neg_q <= neg_in;
          acc   <= acc_in;
          opnd  <= opnd_in;
          cnt   <= CNT_W'(XLEN - 1);
        end
        CALC: if (!kill) begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
        end
        FINISH: if (!kill) begin
          result <= fin;
          rd_out <= rd_q;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking scoreboard testbench for mul_div_unit
module tb_mul_div_unit;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] operand_a, operand_b, result;
  logic [4:0]  rd_in, rd_out;
  logic        busy, done;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          issue_n = 0;
  logic [36:0] sb_q[$];
  logic [36:0] mon_exp;

  mul_div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .kill      (kill),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every DONE must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: rd=%0d result=%h, required no DONE", rd_out, result);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({rd_out, result} !== mon_exp) begin
          fails++;
          $display("FAIL result: rd=%0d result=%h, required rd=%0d result=%h",
                   rd_out, result, mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] sq;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = '0;
    case (f)
      3'd0: begin p = ua * ub; model = p[31:0];  end
      3'd1: begin p = sa * sb; model = p[63:32]; end
      3'd2: begin p = sa * ub; model = p[63:32]; end
      3'd3: begin p = ua * ub; model = p[63:32]; end
      3'd4: begin
        if (b == 0) model = 32'hFFFF_FFFF;
        else if (ovf) model = 32'h8000_0000;
        else begin sq = $signed(a) / $signed(b); model = sq; end
      end
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) model = a;
        else if (ovf) model = 32'h0;
        else begin sq = $signed(a) % $signed(b); model = sq; end
      end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit push, input logic [31:0] exp);
    @(posedge clk); #1;
    funct3 = f; operand_a = a; operand_b = b; rd_in = r; start = 1'b1;
    issue_n = cyc;
    if (push) sb_q.push_back({r, exp});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - issue_n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; kill = 1'b0;
    funct3 = '0; operand_a = '0; operand_b = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done, result, rd_out} !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b result=%h rd=%0d, required all 0", busy, done, result, rd_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul_timing;
    int busy_err = 0;
    int done_err = 0;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (busy !== (k <= 33)) busy_err++;
      if (done !== (k == 34)) done_err++;
    end
    tests++;
    if (busy_err != 0) begin
      fails++;
      $display("FAIL mul_busy_profile: %0d bad cycles, required busy high N+1..N+33 only", busy_err);
    end
    tests++;
    if (done_err != 0) begin
      fails++;
      $display("FAIL mul_done_profile: %0d bad cycles, required done only at N+34", done_err);
    end
  endtask

  task automatic test_mulh;
    vec_t tbl[$];
    int lat;
    tbl.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
    tbl.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    tbl.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
    foreach (tbl[i]) begin
      issue(tbl[i].f, tbl[i].a, tbl[i].b, 5'(i + 1), 1'b1, tbl[i].exp);
      wait_done(lat);
      tests++;
      if (lat !== tbl[i].lat) begin
        fails++;
        $display("FAIL mulh_latency[%0d]: %0d cycles, required %0d", i, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_div;
    vec_t tbl[$];
    int lat;
    tbl.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34});
    tbl.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34});
    tbl.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 34});
    tbl.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 34});
    foreach (tbl[i]) begin
      issue(tbl[i].f, tbl[i].a, tbl[i].b, 5'(i + 10), 1'b1, tbl[i].exp);
      wait_done(lat);
      tests++;
      if (lat !== tbl[i].lat) begin
        fails++;
        $display("FAIL div_latency[%0d]: %0d cycles, required %0d", i, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_div_special;
    vec_t tbl[$];
    int lat;
    tbl.push_back('{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2});
    tbl.push_back('{3'd7, 32'd5, 32'd0, 32'd5, 2});
    tbl.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
    tbl.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2});
    tbl.push_back('{3'd6, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 2});
    foreach (tbl[i]) begin
      issue(tbl[i].f, tbl[i].a, tbl[i].b, 5'(i + 20), 1'b1, tbl[i].exp);
      wait_done(lat);
      tests++;
      if (lat !== tbl[i].lat) begin
        fails++;
        $display("FAIL special_latency[%0d]: %0d cycles, required %0d", i, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0]  f;
    logic [31:0] a, b;
    int lat, exp_lat;
    for (int i = 0; i < 10; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      exp_lat = (f[2] && b == 0) ? 2 : 34;
      issue(f, a, b, 5'(i), 1'b1, model(f, a, b));
      wait_done(lat);
      tests++;
      if (lat !== exp_lat) begin
        fails++;
        $display("FAIL random_latency[%0d]: f=%0d %0d cycles, required %0d", i, f, lat, exp_lat);
      end
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    int extra = 0;
    issue(3'd5, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14);
    while (cyc < issue_n + 10) @(posedge clk);
    #1;
    funct3 = 3'd0; operand_a = 32'd3; operand_b = 32'd4; rd_in = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    tests++;
    if (lat !== 34) begin
      fails++;
      $display("FAIL start_busy_latency: %0d cycles, required 34", lat);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL start_busy_queued: %0d extra DONEs, required 0", extra);
    end
  endtask

  task automatic test_kill;
    int extra = 0;
    issue(3'd4, 32'd1000, 32'd3, 5'd4, 1'b0, 32'd0);
    while (cyc < issue_n + 15) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL kill_busy: busy=%b at N+16, required 0", busy);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL kill_done: %0d DONEs after kill, required 0", extra);
    end
    tests++;
    if ({rd_out, result} !== {5'd3, 32'd14}) begin
      fails++;
      $display("FAIL kill_hold: rd=%0d result=%h, required rd=3 result=0000000e", rd_out, result);
    end
    // KILL in IDLE drops a simultaneous START.
    @(posedge clk); #1;
    funct3 = 3'd0; operand_a = 32'd2; operand_b = 32'd2; rd_in = 5'd1; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL kill_idle: busy=%b after START with KILL, required 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    issue(3'd0, 32'd5, 32'd6, 5'd11, 1'b0, 32'd0);
    while (cyc < issue_n + 5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, result, rd_out} !== '0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h rd=%0d, required all 0", busy, done, result, rd_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(3'd5, 32'd100, 32'd7, 5'd2, 1'b1, 32'd14);
    wait_done(lat);
    tests++;
    if (lat !== 34) begin
      fails++;
      $display("FAIL b2b_first_latency: %0d cycles, required 34", lat);
    end
    // Still inside the DONE cycle: the unit is IDLE and must take this request.
    funct3 = 3'd0; operand_a = 32'd3; operand_b = 32'd4; rd_in = 5'd9; start = 1'b1;
    issue_n = cyc;
    sb_q.push_back({5'd9, 32'd12});
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    tests++;
    if (lat !== 34) begin
      fails++;
      $display("FAIL b2b_second_latency: %0d cycles, required 34", lat);
    end
  endtask

  initial begin
    test_reset;
    test_mul_timing;
    test_mulh;
    test_div;
    test_div_special;
    test_random;
    test_start_ignored;
    test_kill;
    test_reset_mid;
    test_back_to_back;
    repeat (3) @(negedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
